// File: rtl/data_mem_io_if.sv
// CPU data-memory port plus the TX valid/ready stream, bundled for data_mem_io.
// The master is the CPU/sink side; the slave is the memory responder.
interface data_mem_io_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] data_Addr;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] io_data;
  logic              io_valid;
  logic              io_ready;

  modport master (
    output data_Addr,
    output write_data,
    output write_enable,
    output io_ready,
    input  read_data,
    input  io_data,
    input  io_valid
  );

  modport slave (
    input  data_Addr,
    input  write_data,
    input  write_enable,
    input  io_ready,
    output read_data,
    output io_data,
    output io_valid
  );
endinterface

// File: rtl/data_mem_io.sv
// Data RAM responder with an 8-word MMIO window: STATUS, TX FIFO push port
// (drained through a valid/ready stream) and a free-running, loadable cycle counter.
module data_mem_io #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 9,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 9'h1E0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_io_if.slave  bus
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] OFS_STATUS = 3'd0;
  localparam logic [2:0] OFS_TXDATA = 3'd1;
  localparam logic [2:0] OFS_CYCLE  = 3'd2;

  logic [DATA_W-1:0] r_mem     [MEM_DEPTH];
  logic [DATA_W-1:0] r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [DATA_W-1:0] r_cycle;

  logic              w_selIo;
  logic [2:0]        w_offset;
  logic              w_ramWe;
  logic              w_ioWe;
  logic              w_push;
  logic              w_pushAccept;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_ovfClr;
  logic              w_cycleWe;
  logic [DATA_W-1:0] w_ioRdata;

  assign w_selIo  = (bus.data_Addr[ADDR_W-1:3] == MMIO_BASE[ADDR_W-1:3]);
  assign w_offset = bus.data_Addr[2:0];
  assign w_ramWe  = bus.write_enable && !w_selIo;
  assign w_ioWe   = bus.write_enable && w_selIo;

  assign w_push    = w_ioWe && (w_offset == OFS_TXDATA);
  assign w_ovfClr  = w_ioWe && (w_offset == OFS_STATUS);
  assign w_cycleWe = w_ioWe && (w_offset == OFS_CYCLE);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = !w_empty && bus.io_ready;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pushAccept = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      r_mem[bus.data_Addr] <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pushAccept) begin
      r_fifoMem[r_wrPtr] <= bus.write_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_pushAccept) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_pushAccept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_pushAccept) begin
        r_ovf <= 1'b1;
      end else if (w_ovfClr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle <= '0;
    end else if (w_cycleWe) begin
      r_cycle <= bus.write_data;
    end else begin
      r_cycle <= r_cycle + DATA_W'(1);
    end
  end

  always_comb begin
    w_ioRdata = '0;
    case (w_offset)
      OFS_STATUS: w_ioRdata[3:0] = {r_ovf, w_full, w_empty, 1'b0};
      OFS_TXDATA: w_ioRdata      = DATA_W'(r_count);
      OFS_CYCLE:  w_ioRdata      = r_cycle;
      default:    w_ioRdata      = '0;
    endcase
  end

  assign bus.read_data = w_selIo ? w_ioRdata : r_mem[bus.data_Addr];
  assign bus.io_valid  = !w_empty;
  assign bus.io_data   = w_empty ? '0 : r_fifoMem[r_rdPtr];

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io; TX stream words are checked against a scoreboard
// queue filled as pushes are issued.
module tb_data_mem_io;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 4;

  localparam logic [8:0] A_STATUS = 9'h1E0;
  localparam logic [8:0] A_TX     = 9'h1E1;
  localparam logic [8:0] A_CYC    = 9'h1E2;
  localparam logic [8:0] A_UNUSED = 9'h1E5;

  logic        clk = 1'b0;
  logic        rst;
  int          nChecks = 0;
  int          nErrors = 0;
  logic [15:0] sbQueue[$];
  logic        expOvf;

  data_mem_io_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem_io #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .MMIO_BASE(9'h1E0),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [8:0] addr, input logic [15:0] data, input logic we);
    bus.data_Addr    = addr;
    bus.write_data   = data;
    bus.write_enable = we;
  endtask

  task automatic writeWord(input logic [8:0] addr, input logic [15:0] data);
    applyStimulus(addr, data, 1'b1);
    tick();
    bus.write_enable = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [8:0] addr, input logic [15:0] exp);
    applyStimulus(addr, 16'h0000, 1'b0);
    #1;
    checkOutput(tag, bus.read_data, exp);
  endtask

  // Called just after a clock edge, when the queue size equals the DUT count.
  task automatic pushTx(input logic [15:0] data);
    if (sbQueue.size() < DEPTH || (bus.io_ready && sbQueue.size() != 0))
      sbQueue.push_back(data);
    else
      expOvf = 1'b1;
    writeWord(A_TX, data);
  endtask

  function automatic logic [15:0] statusModel();
    return {12'b0, expOvf, sbQueue.size() == DEPTH, sbQueue.size() == 0, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.io_valid === 1'b1 && bus.io_ready === 1'b1) begin
      nChecks++;
      assert (sbQueue.size() != 0) else begin
        nErrors++;
        $error("[TB] FAIL sbUnderflow: observed pop of %h with 0 queued, required none", bus.io_data);
      end
      if (sbQueue.size() != 0) checkOutput("ioData", bus.io_data, sbQueue.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.io_ready = 1'b0;
    expOvf = 1'b0;
    applyStimulus(9'h000, 16'h0000, 1'b0);
    #2;
    checkOutput("rstValid", {15'b0, bus.io_valid}, 16'h0000);
    checkOutput("rstIoData", bus.io_data, 16'h0000);
    readCheck("rstStatus", A_STATUS, 16'h0002);
    readCheck("rstCycle", A_CYC, 16'h0000);
    #11;
    rst = 1'b1;
    tick();
    readCheck("cycleFirst", A_CYC, 16'h0001);

    // RAM access and read-during-write
    writeWord(9'h010, 16'hBEEF);
    readCheck("ramRead", 9'h010, 16'hBEEF);
    writeWord(9'h1FF, 16'h0123);
    readCheck("ramStack", 9'h1FF, 16'h0123);
    writeWord(9'h020, 16'h1111);
    applyStimulus(9'h020, 16'h2222, 1'b1);
    #1;
    checkOutput("rdwOld", bus.read_data, 16'h1111);
    tick();
    bus.write_enable = 1'b0;
    readCheck("rdwNew", 9'h020, 16'h2222);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) pushTx(16'(i));
    readCheck("txCount4", A_TX, 16'h0004);
    readCheck("statusFull", A_STATUS, 16'h0004);
    pushTx(16'h0005);
    readCheck("statusOvf", A_STATUS, 16'h000C);
    bus.io_ready = 1'b1;
    repeat (4) tick();
    checkOutput("drain1Left", 16'(sbQueue.size()), 16'h0000);
    checkOutput("drain1Valid", {15'b0, bus.io_valid}, 16'h0000);
    checkOutput("drain1IoData", bus.io_data, 16'h0000);
    readCheck("ovfSticky", A_STATUS, statusModel());

    // Clear ovf
    writeWord(A_STATUS, 16'h5A5A);
    expOvf = 1'b0;
    readCheck("ovfCleared", A_STATUS, 16'h0002);

    // Push into a full FIFO while the head is popped
    bus.io_ready = 1'b0;
    for (int i = 0; i < 4; i++) pushTx(16'h0011 + 16'(i));
    bus.io_ready = 1'b1;
    pushTx(16'hAAAA);
    bus.io_ready = 1'b0;
    readCheck("simulCount", A_TX, 16'h0004);
    readCheck("simulStatus", A_STATUS, 16'h0004);
    bus.io_ready = 1'b1;
    repeat (4) tick();
    checkOutput("drain2Left", 16'(sbQueue.size()), 16'h0000);

    // Overflow again, then clear while still full
    bus.io_ready = 1'b0;
    for (int i = 0; i < 5; i++) pushTx(16'h0041 + 16'(i));
    readCheck("ovfAgain", A_STATUS, 16'h000C);
    writeWord(A_STATUS, 16'h0000);
    expOvf = 1'b0;
    readCheck("ovfClrFull", A_STATUS, 16'h0004);
    bus.io_ready = 1'b1;
    repeat (4) tick();
    checkOutput("drain3Left", 16'(sbQueue.size()), 16'h0000);

    // Cycle counter load and wrap, unused offset
    writeWord(A_CYC, 16'hFFFE);
    readCheck("cycLoad", A_CYC, 16'hFFFE);
    tick();
    readCheck("cycFFFF", A_CYC, 16'hFFFF);
    tick();
    readCheck("cycWrap", A_CYC, 16'h0000);
    writeWord(A_UNUSED, 16'h1234);
    readCheck("unusedRead", A_UNUSED, 16'h0000);
    readCheck("unusedSide", A_STATUS, statusModel());

    // Asynchronous reset with words queued
    bus.io_ready = 1'b0;
    for (int i = 0; i < 3; i++) pushTx(16'h0031 + 16'(i));
    readCheck("preRstCount", A_TX, 16'h0003);
    tick();
    #1;
    rst = 1'b0;
    sbQueue.delete();
    expOvf = 1'b0;
    #1;
    checkOutput("asyncValid", {15'b0, bus.io_valid}, 16'h0000);
    checkOutput("asyncIoData", bus.io_data, 16'h0000);
    readCheck("asyncCount", A_TX, 16'h0000);
    readCheck("asyncCycle", A_CYC, 16'h0000);
    readCheck("asyncStatus", A_STATUS, 16'h0002);
    #1;
    rst = 1'b1;
    tick();
    readCheck("ramAfterRst", 9'h010, 16'hBEEF);
    readCheck("cycAfterRst", A_CYC, 16'h0001);

    pushTx(16'h7777);
    readCheck("postRstCount", A_TX, 16'h0001);
    bus.io_ready = 1'b1;
    repeat (2) tick();
    checkOutput("drain4Left", 16'(sbQueue.size()), 16'h0000);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
